// File: rtl/operand_entry.sv
// operand_entry: keypad operand accumulator feeding the sign-magnitude to
// two's-complement converter. Decimal digit strobes build a binary magnitude
// with a separate sign. Enter commits the operand behind a valid/ready
// handshake. Digits that would exceed the magnitude range are rejected.
//
// Optional build macro: OPERAND_ENTRY_BACKSPACE_EN enables key 4'hB
// (backspace, divides the working magnitude by ten while typing).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | working value is 0, no key seen since the last commit/clear
// ENTRY | at least one digit or sign toggle accepted
// WAIT  | operand committed, valid high until the downstream takes it
module operand_entry #(
  parameter int bits       = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keyValid,
  input  logic [3:0]      keyCode,
  input  logic            ready,
  output logic [bits-1:0] value,
  output logic            sign,
  output logic            valid,
  output logic            entering,
  output logic            overflow,
  output logic [bits-1:0] liveMag,
  output logic            liveSign
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int NW = bits + 4;

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hE;
`ifdef OPERAND_ENTRY_BACKSPACE_EN
  localparam logic [3:0] KEY_BACK  = 4'hB;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [bits-1:0] mag, mag_nxt;
  logic            live_sign, live_sign_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [bits-1:0] value_nxt;
  logic            sign_nxt;
  logic            valid_nxt;
  logic            overflow_nxt;

  logic [NW-1:0]   scaled;
  logic            is_digit;
  logic            digit_fits;

  // mag*10 + d built from shifts; the four extra bits catch any carry out
  assign scaled     = ({4'b0000, mag} << 3) + ({4'b0000, mag} << 1)
                    + {{bits{1'b0}}, keyCode};
  assign is_digit   = (keyCode <= 4'd9);
  assign digit_fits = (scaled[NW-1:bits] == 4'b0000)
                    && (count != CW'(MAX_DIGITS));

`ifdef OPERAND_ENTRY_BACKSPACE_EN
  logic [bits-1:0] mag_div10;

  assign mag_div10 = mag / bits'(10);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next working/committed values for one keypad strobe
  always_comb begin
    state_nxt     = state;
    mag_nxt       = mag;
    live_sign_nxt = live_sign;
    count_nxt     = count;
    value_nxt     = value;
    sign_nxt      = sign;
    valid_nxt     = valid;
    overflow_nxt  = 1'b0;

    case (state)
      IDLE, ENTRY: begin
        if (keyValid) begin
          if (is_digit) begin
            if (digit_fits) begin
              mag_nxt   = scaled[bits-1:0];
              state_nxt = ENTRY;
              // leading zeros do not use up a digit position
              if (scaled != '0) begin
                count_nxt = count + CW'(1);
              end
            end else begin
              overflow_nxt = 1'b1;
            end
          end else if (keyCode == KEY_SIGN) begin
            live_sign_nxt = ~live_sign;
            state_nxt     = ENTRY;
          end else if (keyCode == KEY_CLEAR) begin
            mag_nxt       = '0;
            live_sign_nxt = 1'b0;
            count_nxt     = '0;
            state_nxt     = IDLE;
          end else if (keyCode == KEY_ENTER) begin
            value_nxt     = mag;
            // a zero magnitude always commits as positive zero
            sign_nxt      = live_sign & (mag != '0);
            valid_nxt     = 1'b1;
            mag_nxt       = '0;
            live_sign_nxt = 1'b0;
            count_nxt     = '0;
            state_nxt     = WAIT;
          end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
          else if ((keyCode == KEY_BACK) && (state == ENTRY)) begin
            mag_nxt = mag_div10;
            if (count != '0) begin
              count_nxt = count - CW'(1);
            end
            if ((mag_div10 == '0) && !live_sign) begin
              state_nxt = IDLE;
            end
          end
`endif
        end
      end
      WAIT: begin
        // keys are dropped silently until the operand is taken
        if (valid && ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working and committed operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mag       <= '0;
      live_sign <= 1'b0;
      count     <= '0;
      value     <= '0;
      sign      <= 1'b0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      mag       <= mag_nxt;
      live_sign <= live_sign_nxt;
      count     <= count_nxt;
      value     <= value_nxt;
      sign      <= sign_nxt;
      valid     <= valid_nxt;
      overflow  <= overflow_nxt;
    end
  end

  assign entering = (state == ENTRY);
  assign liveMag  = mag;
  assign liveSign = live_sign;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed keypad sequences followed by random
// keystrokes, each edge compared with a decimal-arithmetic model.
module tb_operand_entry;

  localparam int BITS = 8;
  localparam int MAXD = 3;
  localparam int MAXV = (2 ** BITS) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            keyValid;
  logic [3:0]      keyCode;
  logic            ready;
  logic [BITS-1:0] value;
  logic            sign;
  logic            valid;
  logic            entering;
  logic            overflow;
  logic [BITS-1:0] liveMag;
  logic            liveSign;

  operand_entry #(.bits(BITS), .MAX_DIGITS(MAXD)) dut (
    .clk      (clk),
    .rst      (rst),
    .keyValid (keyValid),
    .keyCode  (keyCode),
    .ready    (ready),
    .value    (value),
    .sign     (sign),
    .valid    (valid),
    .entering (entering),
    .overflow (overflow),
    .liveMag  (liveMag),
    .liveSign (liveSign)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model: typing phase 0 = nothing typed, 1 = typing, 2 = operand pending
  int m_phase, m_mag, m_sign, m_digits, m_value, m_vsign, m_valid, m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic kv, input logic [3:0] kc, input logic rd, input logic rs);
    int n;
    int ovf;
    ovf = 0;
    if (rs) begin
      m_phase = 0; m_mag = 0; m_sign = 0; m_digits = 0;
      m_value = 0; m_vsign = 0; m_valid = 0;
    end else if (m_phase == 2) begin
      if (rd) begin
        m_valid = 0;
        m_phase = 0;
      end
    end else if (kv) begin
      if (kc <= 9) begin
        n = m_mag * 10 + int'(kc);
        if (n > MAXV || m_digits == MAXD) begin
          ovf = 1;
        end else begin
          m_mag = n;
          if (n != 0) m_digits++;
          m_phase = 1;
        end
      end else if (kc == 4'hA) begin
        m_sign  = 1 - m_sign;
        m_phase = 1;
      end else if (kc == 4'hC) begin
        m_mag = 0; m_sign = 0; m_digits = 0; m_phase = 0;
      end else if (kc == 4'hE) begin
        m_value = m_mag;
        m_vsign = (m_sign == 1 && m_mag != 0) ? 1 : 0;
        m_valid = 1;
        m_mag = 0; m_sign = 0; m_digits = 0; m_phase = 2;
      end
`ifdef OPERAND_ENTRY_BACKSPACE_EN
      else if (kc == 4'hB && m_phase == 1) begin
        m_mag = m_mag / 10;
        if (m_digits > 0) m_digits--;
        if (m_mag == 0 && m_sign == 0) m_phase = 0;
      end
`endif
    end
    m_ovf = rs ? 0 : ovf;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".liveMag"},  liveMag,  m_mag);
    chk({tag, ".liveSign"}, liveSign, m_sign);
    chk({tag, ".value"},    value,    m_value);
    chk({tag, ".sign"},     sign,     m_vsign);
    chk({tag, ".valid"},    valid,    m_valid);
    chk({tag, ".entering"}, entering, (m_phase == 1) ? 1 : 0);
    chk({tag, ".overflow"}, overflow, m_ovf);
  endtask

  task automatic step(input string tag, input logic kv, input logic [3:0] kc,
                      input logic rd, input logic rs);
    rst      = rs;
    keyValid = kv;
    keyCode  = kc;
    ready    = rd;
    @(posedge clk);
    #1;
    model_edge(kv, kc, rd, rs);
    check_all(tag);
    keyValid = 1'b0;
  endtask

  task automatic key(input string tag, input logic [3:0] kc, input logic rd);
    step(tag, 1'b1, kc, rd, 1'b0);
  endtask

  task automatic idle(input string tag, input logic rd);
    step(tag, 1'b0, 4'h0, rd, 1'b0);
  endtask

  initial begin
    logic       r_kv, r_rd, r_rs;
    logic [3:0] r_kc;
    rst = 1'b1; keyValid = 1'b0; keyCode = 4'h0; ready = 1'b0;
    m_phase = 0; m_mag = 0; m_sign = 0; m_digits = 0;
    m_value = 0; m_vsign = 0; m_valid = 0; m_ovf = 0;

    step("reset", 1'b0, 4'h0, 1'b0, 1'b1);
    idle("reset_rel", 1'b0);

    // 1,2,7,E with ready high: valid for exactly one cycle
    key("t1_k1", 4'h1, 1'b1);
    chk("t1_live1", liveMag, 1);
    key("t1_k2", 4'h2, 1'b1);
    chk("t1_live12", liveMag, 12);
    key("t1_k7", 4'h7, 1'b1);
    chk("t1_live127", liveMag, 127);
    key("t1_ent", 4'hE, 1'b1);
    chk("t1_value", value, 127);
    chk("t1_valid", valid, 1);
    idle("t1_done", 1'b1);
    chk("t1_valid_drop", valid, 0);

    // negative full-scale operand
    key("t2_a", 4'hA, 1'b0);
    key("t2_2", 4'h2, 1'b0);
    key("t2_5", 4'h5, 1'b0);
    key("t2_5b", 4'h5, 1'b0);
    key("t2_ent", 4'hE, 1'b0);
    chk("t2_value", value, 255);
    chk("t2_sign", sign, 1);
    idle("t2_take", 1'b1);

    // 256 is out of range
    key("t3_2", 4'h2, 1'b0);
    key("t3_5", 4'h5, 1'b0);
    key("t3_6", 4'h6, 1'b0);
    chk("t3_ovf", overflow, 1);
    chk("t3_keep25", liveMag, 25);
    idle("t3_ovf_end", 1'b0);
    chk("t3_ovf_drop", overflow, 0);
    key("t3_ent", 4'hE, 1'b0);
    chk("t3_value", value, 25);
    idle("t3_take", 1'b1);

    // negative zero is never committed
    key("t4_a", 4'hA, 1'b1);
    key("t4_ent", 4'hE, 1'b1);
    chk("t4_sign", sign, 0);
    idle("t4_take", 1'b1);

    // leading zeros do not use up digit positions
    key("t5_0", 4'h0, 1'b1);
    key("t5_0b", 4'h0, 1'b1);
    key("t5_4", 4'h4, 1'b1);
    key("t5_2", 4'h2, 1'b1);
    key("t5_ent", 4'hE, 1'b1);
    chk("t5_value", value, 42);
    idle("t5_take", 1'b1);

    // stalled handshake, keys dropped while pending
    key("t6_9", 4'h9, 1'b0);
    key("t6_ent", 4'hE, 1'b0);
    key("t6_w5", 4'h5, 1'b0);
    key("t6_wc", 4'hC, 1'b0);
    idle("t6_w", 1'b0);
    chk("t6_hold_value", value, 9);
    chk("t6_hold_valid", valid, 1);
    idle("t6_take", 1'b1);
    chk("t6_valid_drop", valid, 0);
    chk("t6_live0", liveMag, 0);

    // reset mid-entry
    key("t7_3", 4'h3, 1'b0);
    key("t7_4", 4'h4, 1'b0);
    step("t7_rst", 1'b1, 4'h5, 1'b0, 1'b1);
    chk("t7_rst_live", liveMag, 0);
    key("t7_7", 4'h7, 1'b0);
    key("t7_ent", 4'hE, 1'b0);
    chk("t7_value", value, 7);
    // reset mid-handshake
    step("t7_rst2", 1'b0, 4'h0, 1'b1, 1'b1);
    chk("t7_rst_valid", valid, 0);

    // backspace sequence
    key("t8_1", 4'h1, 1'b0);
    key("t8_2", 4'h2, 1'b0);
    key("t8_3", 4'h3, 1'b0);
    key("t8_b", 4'hB, 1'b0);
    key("t8_b2", 4'hB, 1'b0);
    key("t8_9", 4'h9, 1'b0);
    key("t8_ent", 4'hE, 1'b0);
`ifdef OPERAND_ENTRY_BACKSPACE_EN
    chk("t8_value", value, 19);
`else
    chk("t8_value", value, 123);
`endif
    idle("t8_take", 1'b1);

    // random keystrokes
    for (int i = 0; i < 600; i++) begin
      r_rs = ($urandom_range(0, 149) == 0);
      r_kv = ($urandom_range(0, 3) != 0);
      r_rd = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       r_kc = 4'hE;
        1:       r_kc = 4'hA;
        2:       r_kc = 4'hB;
        3:       r_kc = ($urandom_range(0, 3) == 0) ? 4'hC : 4'(4'hD + $urandom_range(0, 2));
        default: r_kc = 4'($urandom_range(0, 9));
      endcase
      step("rand", r_kv, r_kc, r_rd, r_rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Upstream stage of the sign-magnitude to two's-complement converter in the calculator datapath.
- Collects decoded keypad strobes (decimal digits, sign toggle, clear, enter) and accumulates a binary magnitude plus a separate sign bit.
- Presents the committed operand (value, sign) to the converter with a valid/ready handshake.
- Rejects entries that would exceed the magnitude range.

Parameters:
- bits, 8: magnitude width; must equal the converter's bits.
- MAX_DIGITS, 3: maximum number of significant decimal digits accepted per operand.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- keyValid  in  1  one-cycle strobe; keyCode is sampled when high.
- keyCode  in  4  key code: 0-9 digit, 4'hA sign toggle, 4'hB backspace (optional feature), 4'hC clear, 4'hE enter; all other codes ignored.
- ready  in  1  downstream accepts the operand while valid is high.
- value  out  bits  committed magnitude.
- sign  out  1  committed sign (1 = negative).
- valid  out  1  committed operand pending.
- entering  out  1  high while an operand is partially typed.
- overflow  out  1  one-cycle pulse when a digit is rejected.
- liveMag  out  bits  working magnitude, for display.
- liveSign  out  1  working sign, for display.

Behaviour:
- Reset: all outputs 0, working magnitude/sign/digit count 0, state IDLE. Reset has priority over every other input, including mid-entry and mid-handshake.
- States:
  - IDLE: working value is 0, no key seen.
  - ENTRY: at least one digit or sign toggle accepted.
  - WAIT: operand committed, valid high.
- Digit d in IDLE/ENTRY:
  - Compute next = mag*10 + d at bits+4 width, using (mag<<3)+(mag<<1).
  - If next > 2^bits-1, or digit count == MAX_DIGITS: reject. mag is unchanged and overflow pulses on the next cycle.
  - Otherwise mag <= next and the state goes to ENTRY.
  - Digit count increments only when next != 0, so leading zeros are not counted.
- Sign toggle (4'hA) in IDLE/ENTRY: liveSign inverts; state goes to ENTRY.
- Clear (4'hC) in IDLE/ENTRY: working mag, sign and count go to 0; state goes to IDLE. The committed value/sign are untouched.
- Enter (4'hE) in IDLE/ENTRY:
  - Commit value <= mag and sign <= liveSign & (mag != 0), so negative zero is never produced.
  - Assert valid on the next cycle, clear the working registers, go to WAIT.
  - Enter in IDLE commits value 0, sign 0.
- WAIT:
  - The transfer completes on an edge where valid & ready. On that edge, valid <= 0 and the state returns to IDLE.
  - value/sign stay stable while valid is high.
  - All keys are dropped, with no overflow pulse.
  - If ready is already high when valid rises, the transfer completes on the first edge, so valid is high for exactly one cycle.
- Latency: key edge to liveMag update is 1 cycle; enter key edge to valid high is 1 cycle.
- entering = (state == ENTRY).
- Only one key is processed per cycle; keyValid is a strobe, so no double counting can occur.

Optional Feature:
- Macro: OPERAND_ENTRY_BACKSPACE_EN.
- Defined: key 4'hB in ENTRY sets mag <= mag/10 (constant divide, combinational) and decrements the digit count if it is nonzero.
  - If the result is mag == 0 and liveSign == 0, the state returns to IDLE.
  - 4'hB in IDLE or WAIT is ignored.
- Undefined: 4'hB is treated as an ignored code; the divider logic is not synthesised.

Test Plan:
- Keys 1,2,7,E with ready=1 → liveMag 1,12,127; valid high for one cycle with value=127, sign=0; then IDLE.
- Keys A,2,5,5,E → value=255, sign=1.
- Keys 2,5,6 → 6 rejected with one overflow pulse, liveMag stays 25. Then E → value=25.
- Keys A,E → value=0, sign=0. Keys 0,0,4,2,E → 0 not counted, value=42 (with MAX_DIGITS=3, the count reaches only 2).
- Handshake: ready=0 for 3 cycles after 9,E → valid, value=9 held stable; keys 5 and C during WAIT are ignored. ready=1 → valid drops on that edge and liveMag stays 0.
- rst pulsed after keys 3,4 → all outputs 0 on the next cycle. Then 7,E → value=7.
- With OPERAND_ENTRY_BACKSPACE_EN: keys 1,2,3,B,B,9,E → value=19. Without the macro, the same sequence yields value=123 (B ignored, 9 rejected with an overflow pulse).
